// File: rtl/imm_extension_pipe.sv
// Decode-stage immediate generator with a 2-entry skid buffer.
// Combinational decode feeds a main/skid register pair behind a valid/ready handshake.
module imm_extension_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  imm_o,
  output logic [2:0]       fmt_o,
  output logic             illegal_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam bit RV64 = (XLEN == 64);

  localparam logic [2:0] F_NONE  = 3'd0;
  localparam logic [2:0] F_I     = 3'd1;
  localparam logic [2:0] F_S     = 3'd2;
  localparam logic [2:0] F_B     = 3'd3;
  localparam logic [2:0] F_U     = 3'd4;
  localparam logic [2:0] F_J     = 3'd5;
  localparam logic [2:0] F_SHAMT = 3'd6;
  localparam logic [2:0] F_ZIMM  = 3'd7;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_FULL
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } ent_t;

  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic            w_shift;
  logic            w_op_imm;
  logic            w_op_imm32;
  logic            w_load;
  logic            w_jalr;
  logic            w_store;
  logic            w_branch;
  logic            w_jal;
  logic            w_lui;
  logic            w_auipc;
  logic            w_system;
  logic            w_op;
  logic            w_fence;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_sh5;
  logic [XLEN-1:0] w_sh6;
  logic [XLEN-1:0] w_zimm;
  logic [XLEN-1:0] w_imm;
  logic [2:0]      w_fmt;
  logic            w_ill;
  ent_t            w_ent;

  assign w_opc   = instr_i[6:0];
  assign w_f3    = instr_i[14:12];
  assign w_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);

  assign w_op_imm   = (w_opc == 7'b0010011);
  assign w_op_imm32 = (w_opc == 7'b0011011);
  assign w_load     = (w_opc == 7'b0000011);
  assign w_jalr     = (w_opc == 7'b1100111);
  assign w_store    = (w_opc == 7'b0100011);
  assign w_branch   = (w_opc == 7'b1100011);
  assign w_jal      = (w_opc == 7'b1101111);
  assign w_lui      = (w_opc == 7'b0110111);
  assign w_auipc    = (w_opc == 7'b0010111);
  assign w_system   = (w_opc == 7'b1110011);
  assign w_op       = (w_opc == 7'b0110011);
  assign w_fence    = (w_opc == 7'b0001111);

  assign w_imm_i = XLEN'($signed(instr_i[31:20]));
  assign w_imm_s = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
  assign w_imm_b = XLEN'($signed({instr_i[31], instr_i[7],
                                  instr_i[30:25], instr_i[11:8],
                                  1'b0}));
  assign w_imm_j = XLEN'($signed({instr_i[31], instr_i[19:12],
                                  instr_i[20], instr_i[30:21],
                                  1'b0}));
  assign w_imm_u = XLEN'($signed({instr_i[31:12], 12'b0}));
  assign w_sh5   = XLEN'(instr_i[24:20]);
  assign w_sh6   = XLEN'(instr_i[25:20]);
  assign w_zimm  = XLEN'(instr_i[19:15]);

  // Opcode compare covers bits [1:0], so non-32-bit encodings fall to default.
  always_comb begin
    w_imm = '0;
    w_fmt = F_NONE;
    w_ill = 1'b0;
    unique case (1'b1)
      w_op_imm: begin
        if (!w_shift) begin
          w_imm = w_imm_i;
          w_fmt = F_I;
        end else if (!RV64 && instr_i[25]) begin
          w_ill = 1'b1;
        end else begin
          w_imm = RV64 ? w_sh6 : w_sh5;
          w_fmt = F_SHAMT;
        end
      end
      w_op_imm32: begin
        if (!RV64) begin
          w_ill = 1'b1;
        end else if (!w_shift) begin
          w_imm = w_imm_i;
          w_fmt = F_I;
        end else if (instr_i[25]) begin
          w_ill = 1'b1;
        end else begin
          w_imm = w_sh5;
          w_fmt = F_SHAMT;
        end
      end
      w_load, w_jalr: begin
        w_imm = w_imm_i;
        w_fmt = F_I;
      end
      w_store: begin
        w_imm = w_imm_s;
        w_fmt = F_S;
      end
      w_branch: begin
        w_imm = w_imm_b;
        w_fmt = F_B;
      end
      w_jal: begin
        w_imm = w_imm_j;
        w_fmt = F_J;
      end
      w_lui, w_auipc: begin
        w_imm = w_imm_u;
        w_fmt = F_U;
      end
      w_system: begin
        if (w_f3[2]) begin
          w_imm = w_zimm;
          w_fmt = F_ZIMM;
        end
      end
      w_op, w_fence: begin
        w_fmt = F_NONE;
      end
      default: begin
        w_ill = 1'b1;
      end
    endcase
  end

  assign w_ent = '{imm: w_imm, fmt: w_fmt, ill: w_ill, tag: tag_i};

  state_t r_state;
  state_t w_state_nxt;
  ent_t   r_main;
  ent_t   r_skid;
  ent_t   w_main_nxt;
  logic   w_main_ld;
  logic   w_skid_ld;
  logic   w_acc;
  logic   w_drain;

  assign in_ready_o  = (r_state != S_FULL);
  assign out_valid_o = (r_state != S_EMPTY);
  assign w_acc       = in_valid_i && in_ready_o;
  assign w_drain     = out_valid_o && out_ready_i;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = w_ent;
    w_main_ld   = 1'b0;
    w_skid_ld   = 1'b0;
    if (flush_i) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_acc) begin
            w_state_nxt = S_ONE;
            w_main_ld   = 1'b1;
          end
        end
        S_ONE: begin
          if (w_acc && !w_drain) begin
            w_state_nxt = S_FULL;
            w_skid_ld   = 1'b1;
          end else if (w_drain && !w_acc) begin
            w_state_nxt = S_EMPTY;
          end else if (w_acc && w_drain) begin
            w_main_ld = 1'b1;
          end
        end
        S_FULL: begin
          if (w_drain) begin
            w_state_nxt = S_ONE;
            w_main_nxt  = r_skid;
            w_main_ld   = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_main_ld) r_main <= w_main_nxt;
      if (w_skid_ld) r_skid <= w_ent;
    end
  end

  assign imm_o     = r_main.imm;
  assign fmt_o     = r_main.fmt;
  assign illegal_o = r_main.ill;
  assign tag_o     = r_main.tag;

endmodule

// File: tb/tb_imm_extension_pipe.sv
// Bench for imm_extension_pipe: XLEN=32 and XLEN=64 instances driven in lockstep.
// Table of decode vectors plus back-pressure, flush and reset sequences.
module tb_imm_extension_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] instr;
  logic [7:0]  tag;
  logic        out_ready;

  logic        rdy32, vld32, ill32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic [7:0]  tag32;

  logic        rdy64, vld64, ill64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [7:0]  tag64;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imm_extension_pipe #(.XLEN(32), .TAG_W(8)) u32 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(rdy32),
    .instr_i(instr), .tag_i(tag),
    .out_valid_o(vld32), .out_ready_i(out_ready),
    .imm_o(imm32), .fmt_o(fmt32),
    .illegal_o(ill32), .tag_o(tag32)
  );

  imm_extension_pipe #(.XLEN(64), .TAG_W(8)) u64 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(rdy64),
    .instr_i(instr), .tag_i(tag),
    .out_valid_o(vld64), .out_ready_i(out_ready),
    .imm_o(imm64), .fmt_o(fmt64),
    .illegal_o(ill64), .tag_o(tag64)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm32;
    logic [2:0]  f32;
    logic        i32;
    logic [63:0] imm64;
    logic [2:0]  f64;
    logic        i64;
  } vec_t;

  vec_t tv[18];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, ".vld"}, {63'b0, vld32}, 64'd0);
    chk({nm, ".rdy"}, {63'b0, rdy32}, 64'd1);
    chk({nm, ".imm"}, {32'b0, imm32}, 64'd0);
    chk({nm, ".fmt"}, {61'b0, fmt32}, 64'd0);
    chk({nm, ".ill"}, {63'b0, ill32}, 64'd0);
    chk({nm, ".tag"}, {56'b0, tag32}, 64'd0);
    chk({nm, ".imm64"}, imm64, 64'd0);
    chk({nm, ".vld64"}, {63'b0, vld64}, 64'd0);
  endtask

  initial begin
    tv[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0,
               64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
    tv[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0,
               64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0};
    tv[2]  = '{32'h300FD073, 32'h0000001F, 3'd7, 1'b0,
               64'h000000000000001F, 3'd7, 1'b0};
    tv[3]  = '{32'h02009093, 32'h00000000, 3'd0, 1'b1,
               64'h0000000000000020, 3'd6, 1'b0};
    tv[4]  = '{32'h800000B7, 32'h80000000, 3'd4, 1'b0,
               64'hFFFFFFFF80000000, 3'd4, 1'b0};
    tv[5]  = '{32'h00000000, 32'h00000000, 3'd0, 1'b1,
               64'h0000000000000000, 3'd0, 1'b1};
    tv[6]  = '{32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0,
               64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0};
    tv[7]  = '{32'h0080006F, 32'h00000008, 3'd5, 1'b0,
               64'h0000000000000008, 3'd5, 1'b0};
    tv[8]  = '{32'h12345097, 32'h12345000, 3'd4, 1'b0,
               64'h0000000012345000, 3'd4, 1'b0};
    tv[9]  = '{32'h002081B3, 32'h00000000, 3'd0, 1'b0,
               64'h0000000000000000, 3'd0, 1'b0};
    tv[10] = '{32'h00000073, 32'h00000000, 3'd0, 1'b0,
               64'h0000000000000000, 3'd0, 1'b0};
    tv[11] = '{32'h80002083, 32'hFFFFF800, 3'd1, 1'b0,
               64'hFFFFFFFFFFFFF800, 3'd1, 1'b0};
    tv[12] = '{32'h0010809B, 32'h00000000, 3'd0, 1'b1,
               64'h0000000000000001, 3'd1, 1'b0};
    tv[13] = '{32'h0200909B, 32'h00000000, 3'd0, 1'b1,
               64'h0000000000000000, 3'd0, 1'b1};
    tv[14] = '{32'h03F09093, 32'h00000000, 3'd0, 1'b1,
               64'h000000000000003F, 3'd6, 1'b0};
    tv[15] = '{32'h40515093, 32'h00000005, 3'd6, 1'b0,
               64'h0000000000000005, 3'd6, 1'b0};
    tv[16] = '{32'h00000001, 32'h00000000, 3'd0, 1'b1,
               64'h0000000000000000, 3'd0, 1'b1};
    tv[17] = '{32'h0FF0000F, 32'h00000000, 3'd0, 1'b0,
               64'h0000000000000000, 3'd0, 1'b0};

    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    instr     = 32'hFFF00093;
    tag       = 8'hAA;
    out_ready = 1'b1;
    tick;
    tick;
    chk_reset_outs("reset");

    rst      = 1'b0;
    in_valid = 1'b0;
    tick;
    chk("idle.vld", {63'b0, vld32}, 64'd0);

    // Streaming table: one vector per cycle, one-cycle latency.
    for (int i = 0; i < 18; i++) begin
      in_valid = 1'b1;
      instr    = tv[i].instr;
      tag      = 8'(i + 8'h40);
      chk($sformatf("v%0d.rdy", i), {63'b0, rdy32}, 64'd1);
      tick;
      chk($sformatf("v%0d.vld", i), {63'b0, vld32}, 64'd1);
      chk($sformatf("v%0d.imm32", i), {32'b0, imm32},
          {32'b0, tv[i].imm32});
      chk($sformatf("v%0d.fmt32", i), {61'b0, fmt32}, {61'b0, tv[i].f32});
      chk($sformatf("v%0d.ill32", i), {63'b0, ill32}, {63'b0, tv[i].i32});
      chk($sformatf("v%0d.tag32", i), {56'b0, tag32}, 64'(i + 8'h40));
      chk($sformatf("v%0d.imm64", i), imm64, tv[i].imm64);
      chk($sformatf("v%0d.fmt64", i), {61'b0, fmt64}, {61'b0, tv[i].f64});
      chk($sformatf("v%0d.ill64", i), {63'b0, ill64}, {63'b0, tv[i].i64});
    end
    in_valid = 1'b0;
    tick;
    chk("drain.vld", {63'b0, vld32}, 64'd0);

    // Back-pressure: tags 1,2 fill the buffer, tag 3 waits.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = 32'hFFF00093;
    tag       = 8'd1;
    tick;
    tag = 8'd2;
    chk("bp.rdy1", {63'b0, rdy32}, 64'd1);
    tick;
    tag = 8'd3;
    chk("bp.rdy_full", {63'b0, rdy32}, 64'd0);
    chk("bp.tag1", {56'b0, tag32}, 64'd1);
    tick;
    chk("bp.hold_tag", {56'b0, tag32}, 64'd1);
    chk("bp.hold_vld", {63'b0, vld32}, 64'd1);
    chk("bp.hold_imm", {32'b0, imm32}, 64'hFFFFFFFF);
    chk("bp.hold_rdy", {63'b0, rdy32}, 64'd0);
    out_ready = 1'b1;
    tick;
    chk("bp.out2", {56'b0, tag32}, 64'd2);
    chk("bp.vld2", {63'b0, vld32}, 64'd1);
    chk("bp.rdy_one", {63'b0, rdy32}, 64'd1);
    tick;
    in_valid = 1'b0;
    chk("bp.out3", {56'b0, tag32}, 64'd3);
    chk("bp.vld3", {63'b0, vld32}, 64'd1);
    tick;
    chk("bp.empty", {63'b0, vld32}, 64'd0);

    // Flush while FULL with an instruction on offer.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    tag       = 8'h11;
    tick;
    tag = 8'h12;
    tick;
    chk("fl.full", {63'b0, rdy32}, 64'd0);
    flush = 1'b1;
    tag   = 8'h13;
    tick;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl.vld", {63'b0, vld32}, 64'd0);
    chk("fl.rdy", {63'b0, rdy32}, 64'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk($sformatf("fl.none%0d", k), {63'b0, vld32}, 64'd0);
    end

    // Flush beats a simultaneous accept and drain in ONE.
    in_valid = 1'b1;
    tag      = 8'h21;
    tick;
    flush = 1'b1;
    tag   = 8'h22;
    tick;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl1.vld", {63'b0, vld32}, 64'd0);
    tick;
    chk("fl1.none", {63'b0, vld32}, 64'd0);

    // Reset mid-stream while FULL, with a simultaneous flush.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = 32'hFE000EE3;
    tag       = 8'h31;
    tick;
    tag = 8'h32;
    tick;
    chk("rs.full", {63'b0, rdy32}, 64'd0);
    rst   = 1'b1;
    flush = 1'b1;
    tag   = 8'h33;
    tick;
    chk_reset_outs("rs");
    tick;
    chk("rs.held", {63'b0, vld32}, 64'd0);
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk($sformatf("rs.none%0d", k), {63'b0, vld32}, 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_extension_pipe.md
# imm_extension_pipe

Pipelined, parametrised immediate generator for the decode stage. It accepts one 32-bit instruction per cycle over a valid/ready handshake and returns the sign- or zero-extended immediate at XLEN width. It also returns a format code, an illegal-encoding flag and a pass-through tag. A 2-entry skid buffer decouples the fetch and execute sides, so back-pressure never combinationally crosses the block.

## Interface
- XLEN, 32: output datapath width; legal values are 32 and 64 only.
- TAG_W, 8: width of the sideband tag (PC index, ROB id, …) carried alongside each instruction.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- flush_i  input  1  synchronous discard of all buffered entries.
- in_valid_i  input  1  instruction present on instr_i.
- in_ready_o  output  1  block can accept an instruction this cycle.
- instr_i  input  32  raw instruction word.
- tag_i  input  TAG_W  sideband tag.
- out_valid_o  output  1  result present.
- out_ready_i  input  1  consumer accepts the result this cycle.
- imm_o  output  XLEN  extended immediate.
- fmt_o  output  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM.
- illegal_o  output  1  unrecognised or illegal encoding.
- tag_o  output  TAG_W  tag of the presented result.

## Operation
- Decode uses opcode = instr_i[6:0] and is combinational. The result is written into the buffer on accept (in_valid_i && in_ready_o).
- Sign bit is instr_i[31] for all signed formats; extension always goes to XLEN.
- OP-IMM (0010011) with funct3 001/101 → SHAMT:
  - Immediate = instr_i[24:20] zero-extended when XLEN=32; instr_i[25:20] zero-extended when XLEN=64.
  - XLEN=32 with instr_i[25]=1 → illegal.
- Other OP-IMM, LOAD (0000011), JALR (1100111) → I: sext(instr_i[31:20]).
- STORE (0100011) → S: sext({[31:25],[11:7]}).
- BRANCH (1100011) → B: sext({[31],[7],[30:25],[11:8],0}).
- JAL (1101111) → J: sext({[31],[19:12],[20],[30:21],0}).
- LUI (0110111), AUIPC (0010111) → U: sext({[31:12],12'b0}). Upper bits are replicated from bit 31 when XLEN=64.
- SYSTEM (1110011):
  - funct3[2]=1 → ZIMM: zext(instr_i[19:15]).
  - Otherwise → NONE, imm 0.
- OP (0110011), FENCE (0001111) → NONE, imm 0, not illegal.
- Any other opcode, or instr_i[1:0] ≠ 2'b11 → NONE, imm 0, illegal_o=1.
- XLEN=64 only: OP-IMM-32 (0011011) follows OP-IMM rules but with a 5-bit shamt (instr_i[25]=1 → illegal). Under XLEN=32 this opcode is illegal.
- Skid buffer states:
  - EMPTY: out_valid_o=0, in_ready_o=1.
  - ONE: main register valid.
  - FULL: main and skid registers valid, in_ready_o=0.
- Transitions:
  - EMPTY —accept→ ONE.
  - ONE —accept & !drain→ FULL; ONE —drain & !accept→ EMPTY; ONE —accept & drain→ ONE, with the main register reloaded.
  - FULL —drain→ ONE, with skid moved to main.
  - drain = out_valid_o && out_ready_i.
- Ordering is strict FIFO; no entry is dropped or duplicated.

## Timing
- Latency: an instruction accepted in cycle N is presented on the outputs in cycle N+1.
- Throughput: 1/cycle while out_ready_i is held high.
- in_ready_o is a function of the state register only; it has no combinational path from out_ready_i.
- Outputs come from the main register. They are stable while out_valid_o && !out_ready_i.
- Reset values: out_valid_o=0, in_ready_o=1 (state EMPTY), imm_o=0, fmt_o=0, illegal_o=0, tag_o=0. While rst_i=1, inputs are ignored.
- flush_i=1 → next cycle state is EMPTY and out_valid_o=0.
  - flush_i overrides a simultaneous accept; that instruction is dropped.
  - flush_i overrides a simultaneous drain.
- rst_i has priority over flush_i.
- Reset asserted mid-stream discards all entries, identically to flush.

## Test plan
- XLEN=32, accept 0xFFF00093 (addi x1,x0,-1) in cycle N → cycle N+1: out_valid_o=1, imm_o=0xFFFFFFFF, fmt_o=1, illegal_o=0.
- Accept 0xFE000EE3 (beq -4) → imm_o=0xFFFFFFFC, fmt_o=3. Then accept 0x300FD073 (csrrwi zimm 31) → imm_o=0x0000001F, fmt_o=7.
- Shift width: 0x02009093 (slli shamt 32) → XLEN=32: illegal_o=1, imm_o=0; XLEN=64: imm_o=0x20, fmt_o=6.
- XLEN=64, accept 0x800000B7 (lui 0x80000) → imm_o=0xFFFFFFFF80000000, fmt_o=4. Accept 0x00000000 → illegal_o=1.
- Back-pressure: out_ready_i=0, offer tags 1,2,3 → tags 1 and 2 accepted, in_ready_o=0 from the cycle after the second accept, tag 3 held. Raise out_ready_i → tags 1,2,3 emerge in order with no gaps.
- With the buffer FULL, assert flush_i together with in_valid_i → next cycle out_valid_o=0, in_ready_o=1, and nothing is ever emitted for the offered instruction. Repeat using rst_i instead: same result, with all outputs at reset values.
